// File: rtl/gauss_mac_seq.sv
// Row/frame sequencer for one 7-tap Gaussian MAC stage: edge-replicated padding,
// row-end flush, per-scale coefficient banks and realignment of MAC results to x/y.
module gauss_mac_seq #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int NUM_SCALES = 4,
  parameter int MAC_LAT    = 3
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        iframe_start,
  input  logic [1:0]  iscale_sel,
  input  logic        ipix_valid,
  input  logic [7:0]  ipix_data,
  output logic        opix_ready,
  input  logic        icfg_we,
  input  logic [1:0]  icfg_scale,
  input  logic [2:0]  icfg_tap,
  input  logic [7:0]  icfg_coef,
  output logic        oMac_dval,
  output logic [8:0]  oMac_data_s,
  output logic [7:0]  oMac_coef_0,
  output logic [7:0]  oMac_coef_1,
  output logic [7:0]  oMac_coef_2,
  output logic [7:0]  oMac_coef_3,
  output logic [7:0]  oMac_coef_4,
  output logic [7:0]  oMac_coef_5,
  output logic [7:0]  oMac_coef_6,
  input  logic [19:0] iMac_odata,
  output logic        oDval,
  output logic [19:0] oData,
  output logic [9:0]  oX,
  output logic [8:0]  oY,
  output logic        oFrame_done,
  output logic        oBusy,
  output logic        oCfg_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LPAD  = 3'd1;
  localparam logic [2:0] S_ROW   = 3'd2;
  localparam logic [2:0] S_RPAD  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Sample count per row reaches IMG_W + 6 + MAC_LAT
  localparam int NW = $clog2(IMG_W + MAC_LAT + 8);
  localparam logic [NW-1:0] ND_FIRST       = NW'(7);
  localparam logic [NW-1:0] ND_LAST        = NW'(IMG_W + 6);
  localparam logic [NW-1:0] CNT_PAD_LAST   = NW'(2);
  localparam logic [NW-1:0] CNT_ROW_LAST   = NW'(IMG_W - 1);
  localparam logic [NW-1:0] CNT_FLUSH_LAST = NW'(MAC_LAT - 1);
  localparam logic [8:0]    Y_LAST         = 9'(IMG_H - 1);

  logic [2:0]    state_reg, state_next;
  logic [NW-1:0] cnt_reg, cnt_next;
  logic [8:0]    y_reg, y_next;
  logic [1:0]    sel_reg, sel_next;
  logic [7:0]    last_pix_reg, last_pix_next;
  logic [NW-1:0] n_reg, n_sum;
  logic          n_clr;
  logic          mac_dval;
  logic [7:0]    mac_pix;
  logic          frame_done_next;

  logic [7:0]    bank_reg [NUM_SCALES][7];
  logic          cfg_err_reg;
  logic          cfg_ok, cfg_bad;

  logic [NW-1:0] nd_pipe [MAC_LAT];
  logic [8:0]    y_pipe  [MAC_LAT];
  logic [NW-1:0] nd_out, last_nd_reg;
  logic [8:0]    y_out;
  logic          hit;

  logic          dval_reg;
  logic [19:0]   data_reg;
  logic [9:0]    x_reg;
  logic [8:0]    yo_reg;
  logic          frame_done_reg;

  // Coefficient banks are writable only while idle and for real taps
  assign cfg_ok  = icfg_we && (state_reg == S_IDLE) && (icfg_tap != 3'd7)
                   && (int'(icfg_scale) < NUM_SCALES);
  assign cfg_bad = icfg_we && ((state_reg != S_IDLE) || (icfg_tap == 3'd7));

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int s = 0; s < NUM_SCALES; s++)
        for (int k = 0; k < 7; k++)
          bank_reg[s][k] <= 8'd0;
      cfg_err_reg <= 1'b0;
    end else begin
      if (cfg_ok)
        bank_reg[icfg_scale][icfg_tap] <= icfg_coef;
      if (cfg_bad)
        cfg_err_reg <= 1'b1;
    end
  end

  logic [7:0] coef_sel [7];
  logic       sel_in_range;
  assign sel_in_range = int'(sel_reg) < NUM_SCALES;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_coef
      assign coef_sel[gi] = sel_in_range ? bank_reg[sel_reg][gi] : 8'd0;
    end
  endgenerate

  assign oMac_coef_0 = coef_sel[0];
  assign oMac_coef_1 = coef_sel[1];
  assign oMac_coef_2 = coef_sel[2];
  assign oMac_coef_3 = coef_sel[3];
  assign oMac_coef_4 = coef_sel[4];
  assign oMac_coef_5 = coef_sel[5];
  assign oMac_coef_6 = coef_sel[6];

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    y_next          = y_reg;
    sel_next        = sel_reg;
    last_pix_next   = last_pix_reg;
    mac_dval        = 1'b0;
    mac_pix         = 8'd0;
    n_clr           = 1'b0;
    frame_done_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (iframe_start) begin
          state_next = S_LPAD;
          y_next     = 9'd0;
          sel_next   = iscale_sel;
          cnt_next   = '0;
          n_clr      = 1'b1;
        end
      end
      S_LPAD: begin
        // Left pad replicates the first pixel of the row without consuming it
        if (ipix_valid) begin
          mac_dval = 1'b1;
          mac_pix  = ipix_data;
          if (cnt_reg == CNT_PAD_LAST) begin
            cnt_next   = '0;
            state_next = S_ROW;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      S_ROW: begin
        if (ipix_valid) begin
          mac_dval      = 1'b1;
          mac_pix       = ipix_data;
          last_pix_next = ipix_data;
          if (cnt_reg == CNT_ROW_LAST) begin
            cnt_next   = '0;
            state_next = S_RPAD;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      S_RPAD: begin
        mac_dval = 1'b1;
        mac_pix  = last_pix_reg;
        if (cnt_reg == CNT_PAD_LAST) begin
          cnt_next   = '0;
          state_next = S_FLUSH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_FLUSH: begin
        mac_dval = 1'b1;
        if (cnt_reg == CNT_FLUSH_LAST) begin
          cnt_next = '0;
          if (y_reg == Y_LAST) begin
            state_next = S_DONE;
          end else begin
            y_next     = y_reg + 1'b1;
            state_next = S_LPAD;
            n_clr      = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        frame_done_next = 1'b1;
        state_next      = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // n_sum counts the current strobe, so the pipeline sees the window it completes
  assign n_sum = n_reg + NW'(mac_dval);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      y_reg        <= 9'd0;
      sel_reg      <= 2'd0;
      last_pix_reg <= 8'd0;
      n_reg        <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      y_reg        <= y_next;
      sel_reg      <= sel_next;
      last_pix_reg <= last_pix_next;
      n_reg        <= n_clr ? '0 : n_sum;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        nd_pipe[i] <= '0;
        y_pipe[i]  <= 9'd0;
      end
    end else begin
      nd_pipe[0] <= n_sum;
      y_pipe[0]  <= y_reg;
      for (int i = 1; i < MAC_LAT; i++) begin
        nd_pipe[i] <= nd_pipe[i-1];
        y_pipe[i]  <= y_pipe[i-1];
      end
    end
  end

  assign nd_out = nd_pipe[MAC_LAT-1];
  assign y_out  = y_pipe[MAC_LAT-1];
  // Gaps hold the count, so repeated captures of one window are filtered here
  assign hit = (nd_out >= ND_FIRST) && (nd_out <= ND_LAST) && (nd_out != last_nd_reg);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      dval_reg       <= 1'b0;
      data_reg       <= 20'd0;
      x_reg          <= 10'd0;
      yo_reg         <= 9'd0;
      last_nd_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      dval_reg       <= hit;
      frame_done_reg <= frame_done_next;
      if (hit) begin
        data_reg    <= iMac_odata;
        x_reg       <= 10'(nd_out - ND_FIRST);
        yo_reg      <= y_out;
        last_nd_reg <= nd_out;
      end
    end
  end

  assign opix_ready  = (state_reg == S_ROW);
  assign oMac_dval   = mac_dval;
  assign oMac_data_s = {1'b0, mac_pix};
  assign oDval       = dval_reg;
  assign oData       = data_reg;
  assign oX          = x_reg;
  assign oY          = yo_reg;
  assign oFrame_done = frame_done_reg;
  assign oBusy       = (state_reg != S_IDLE);
  assign oCfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_gauss_mac_seq.sv
// Bench for gauss_mac_seq: emulated 7-tap MAC, padded-convolution reference model,
// directed frames with random pixels, coefficients and valid gaps.
module tb_gauss_mac_seq;

  localparam int IMG_W      = 8;
  localparam int IMG_H      = 2;
  localparam int NUM_SCALES = 4;
  localparam int MAC_LAT    = 3;
  localparam int NPIX       = IMG_W * IMG_H;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic        iframe_start;
  logic [1:0]  iscale_sel;
  logic        ipix_valid;
  logic [7:0]  ipix_data;
  logic        opix_ready;
  logic        icfg_we;
  logic [1:0]  icfg_scale;
  logic [2:0]  icfg_tap;
  logic [7:0]  icfg_coef;
  logic        oMac_dval;
  logic [8:0]  oMac_data_s;
  logic [7:0]  oMac_coef_0, oMac_coef_1, oMac_coef_2, oMac_coef_3;
  logic [7:0]  oMac_coef_4, oMac_coef_5, oMac_coef_6;
  logic [19:0] iMac_odata;
  logic        oDval;
  logic [19:0] oData;
  logic [9:0]  oX;
  logic [8:0]  oY;
  logic        oFrame_done;
  logic        oBusy;
  logic        oCfg_err;

  int checks = 0;
  int errors = 0;
  int pix [NPIX];
  int cm [NUM_SCALES][7];
  int got_x [$];
  int got_y [$];
  int got_d [$];
  int ref_d [$];
  int done_cnt;
  int res_at_done;

  always #5 iclk = ~iclk;

  gauss_mac_seq #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_SCALES(NUM_SCALES), .MAC_LAT(MAC_LAT)
  ) dut (
    .iclk(iclk), .irst_n(irst_n), .iframe_start(iframe_start), .iscale_sel(iscale_sel),
    .ipix_valid(ipix_valid), .ipix_data(ipix_data), .opix_ready(opix_ready),
    .icfg_we(icfg_we), .icfg_scale(icfg_scale), .icfg_tap(icfg_tap), .icfg_coef(icfg_coef),
    .oMac_dval(oMac_dval), .oMac_data_s(oMac_data_s),
    .oMac_coef_0(oMac_coef_0), .oMac_coef_1(oMac_coef_1), .oMac_coef_2(oMac_coef_2),
    .oMac_coef_3(oMac_coef_3), .oMac_coef_4(oMac_coef_4), .oMac_coef_5(oMac_coef_5),
    .oMac_coef_6(oMac_coef_6), .iMac_odata(iMac_odata),
    .oDval(oDval), .oData(oData), .oX(oX), .oY(oY),
    .oFrame_done(oFrame_done), .oBusy(oBusy), .oCfg_err(oCfg_err)
  );

  // MAC stand-in: 7-sample window, sum visible MAC_LAT cycles after the strobe
  logic [7:0] cf [7];
  logic [7:0] win [7] = '{default: 8'd0};
  int         dly [MAC_LAT] = '{default: 0};
  assign cf[0] = oMac_coef_0;
  assign cf[1] = oMac_coef_1;
  assign cf[2] = oMac_coef_2;
  assign cf[3] = oMac_coef_3;
  assign cf[4] = oMac_coef_4;
  assign cf[5] = oMac_coef_5;
  assign cf[6] = oMac_coef_6;
  assign iMac_odata = 20'(dly[MAC_LAT-1]);

  always @(posedge iclk) begin : mac_emu
    logic [7:0] wn [7];
    int s;
    for (int k = 0; k < 7; k++) wn[k] = win[k];
    if (oMac_dval) begin
      for (int k = 0; k < 6; k++) wn[k] = win[k+1];
      wn[6] = oMac_data_s[7:0];
    end
    s = 0;
    for (int k = 0; k < 7; k++) s += int'(cf[k]) * int'(wn[k]);
    win    <= wn;
    dly[0] <= s;
    for (int i = 1; i < MAC_LAT; i++) dly[i] <= dly[i-1];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic outs_or();
    return |{opix_ready, oMac_dval, oMac_data_s, oMac_coef_0, oMac_coef_1, oMac_coef_2,
             oMac_coef_3, oMac_coef_4, oMac_coef_5, oMac_coef_6, oDval, oData, oX, oY,
             oFrame_done, oBusy, oCfg_err};
  endfunction

  // Reference: 7-tap convolution over the row with edge-replicated borders
  function automatic int exp_val(input int scale, input int y, input int x);
    int s = 0;
    for (int k = 0; k < 7; k++) begin
      int c = x + k - 3;
      if (c < 0) c = 0;
      if (c > IMG_W - 1) c = IMG_W - 1;
      s += cm[scale][k] * pix[y * IMG_W + c];
    end
    return s;
  endfunction

  task automatic cfg_write(input int s, input int t, input int c);
    @(negedge iclk);
    icfg_we = 1'b1; icfg_scale = 2'(s); icfg_tap = 3'(t); icfg_coef = 8'(c);
    @(negedge iclk);
    icfg_we = 1'b0;
    if (t <= 6) cm[s][t] = c;
  endtask

  task automatic run_frame(input int scale, input int gap_max, input int abort_at, input bit cfg_mid);
    int pi = 0;
    int gap = 0;
    int post = 0;
    bit acc = 1'b0;
    got_x.delete(); got_y.delete(); got_d.delete();
    done_cnt = 0; res_at_done = -1;
    @(negedge iclk);
    iframe_start = 1'b1; iscale_sel = 2'(scale);
    @(negedge iclk);
    iframe_start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge iclk);
      if (oDval) begin
        got_x.push_back(int'(oX)); got_y.push_back(int'(oY)); got_d.push_back(int'(oData));
      end
      if (oFrame_done) begin
        done_cnt++; res_at_done = got_d.size();
      end
      if (done_cnt > 0) begin
        post++;
        if (post > 3) break;
      end
      if (acc) begin
        pi++;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      end
      if (abort_at >= 0 && pi == abort_at) begin
        irst_n = 1'b0; ipix_valid = 1'b0;
        break;
      end
      if (gap > 0) begin
        ipix_valid = 1'b0; ipix_data = 8'($urandom); gap--;
      end else if (pi < NPIX) begin
        ipix_valid = 1'b1; ipix_data = 8'(pix[pi]);
      end else begin
        ipix_valid = 1'b0;
      end
      icfg_we      = cfg_mid && (cyc == 5);
      icfg_scale   = 2'd0; icfg_tap = 3'd3; icfg_coef = 8'h5A;
      iframe_start = cfg_mid && (cyc == 8);
      iscale_sel   = (cfg_mid && cyc == 8) ? 2'd3 : 2'(scale);
      acc = ipix_valid && opix_ready;
    end
    ipix_valid = 1'b0; icfg_we = 1'b0; iframe_start = 1'b0;
    if (abort_at < 0) begin
      chk("frame_done_count", done_cnt, 1);
      chk("results_before_done", res_at_done, NPIX);
    end
  endtask

  task automatic compare_frame(input int scale);
    chk("result_count", got_d.size(), NPIX);
    for (int i = 0; i < got_d.size() && i < NPIX; i++) begin
      int y = i / IMG_W;
      int x = i % IMG_W;
      chk("result_xy", {32'(got_y[i]), 32'(got_x[i])}, {32'(y), 32'(x)});
      chk("result_data", got_d[i], exp_val(scale, y, x));
    end
  endtask

  initial begin
    bit same;
    irst_n = 1'b0; iframe_start = 1'b0; iscale_sel = 2'd0; ipix_valid = 1'b0; ipix_data = 8'd0;
    icfg_we = 1'b0; icfg_scale = 2'd0; icfg_tap = 3'd0; icfg_coef = 8'd0;
    for (int s = 0; s < NUM_SCALES; s++) for (int k = 0; k < 7; k++) cm[s][k] = 0;
    repeat (3) @(negedge iclk);
    chk("reset_outputs", 64'(outs_or()), 0);
    irst_n = 1'b1;

    // Center tap only: results reproduce the row
    cfg_write(0, 3, 1);
    for (int i = 0; i < NPIX; i++) pix[i] = (i % IMG_W) + 1;
    run_frame(0, 0, -1, 1'b0);
    compare_frame(0);
    chk("t1_x0", got_d[0], 1);
    chk("t1_row1_y", got_y[IMG_W], 1);

    // Box filter on bank 1
    for (int k = 0; k < 7; k++) cfg_write(1, k, 1);
    for (int i = 0; i < NPIX; i++) pix[i] = 10;
    run_frame(1, 0, -1, 1'b0);
    compare_frame(1);
    chk("t2_const70", got_d[5], 70);
    for (int i = 0; i < NPIX; i++) pix[i] = (i % IMG_W) + 1;
    run_frame(1, 0, -1, 1'b0);
    compare_frame(1);
    chk("t2_left_edge", got_d[0], 13);
    chk("t2_right_edge", got_d[7], 50);

    // Random data, contiguous then with random valid gaps
    for (int k = 0; k < 7; k++) cfg_write(2, k, int'($urandom_range(255, 0)));
    for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(255, 0));
    run_frame(2, 0, -1, 1'b0);
    compare_frame(2);
    ref_d = got_d;
    run_frame(2, 5, -1, 1'b0);
    compare_frame(2);
    same = (got_d.size() == ref_d.size());
    for (int i = 0; i < got_d.size() && i < ref_d.size(); i++)
      if (got_d[i] != ref_d[i]) same = 1'b0;
    chk("gap_vs_contiguous", 64'(same), 1);

    // Busy write and a restart pulse mid-frame are both ignored
    for (int i = 0; i < NPIX; i++) pix[i] = (i % IMG_W) + 1;
    run_frame(0, 0, -1, 1'b1);
    compare_frame(0);
    chk("cfg_err_busy", 64'(oCfg_err), 1);
    run_frame(0, 0, -1, 1'b0);
    compare_frame(0);

    // Abort during row 1
    run_frame(0, 3, IMG_W + 3, 1'b0);
    #1;
    chk("abort_outputs_zero", 64'(outs_or()), 0);
    chk("abort_no_done", done_cnt, 0);
    for (int s = 0; s < NUM_SCALES; s++) for (int k = 0; k < 7; k++) cm[s][k] = 0;
    @(negedge iclk);
    irst_n = 1'b1;
    @(negedge iclk);
    chk("cfg_err_cleared", 64'(oCfg_err), 0);
    cfg_write(0, 7, 8'h33);
    chk("cfg_err_tap7", 64'(oCfg_err), 1);
    cfg_write(0, 3, 1);
    for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(255, 0));
    run_frame(0, 2, -1, 1'b0);
    compare_frame(0);

    // Full-scale coefficients and pixels
    for (int k = 0; k < 7; k++) cfg_write(3, k, 255);
    for (int i = 0; i < NPIX; i++) pix[i] = 255;
    run_frame(3, 1, -1, 1'b0);
    compare_frame(3);
    chk("max_value", got_d[3], 455175);
    chk("max_bit19", 64'(got_d[3] >>> 19), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gauss_mac_seq.md
Name: gauss_mac_seq

Overview:
- Row/frame sequencer for one 7-tap sign-magnitude MAC stage of the SIFT Gaussian blur.
- Accepts a raster pixel stream and inserts edge-replicated left/right padding plus a row-end flush.
- Drives the MAC's data-valid strobe, pixel and 7 coefficients, which come from a per-scale coefficient bank.
- Recovers exactly IMG_W aligned results per row from the MAC's fixed-pipeline output, tagged with x/y, tolerating arbitrary upstream valid gaps.

Parameters:
IMG_W, 640, pixels per row (>=4)
IMG_H, 480, rows per frame
NUM_SCALES, 4, coefficient banks (one per blur scale)
MAC_LAT, 3, cycles from a strobe on oMac_dval until that sample's window is captured by the MAC

Ports:
iclk  in  1  clock
irst_n  in  1  async active-low reset
iframe_start  in  1  1-cycle pulse; starts a frame when IDLE
iscale_sel  in  2  bank select, sampled on accepted iframe_start
ipix_valid  in  1  upstream pixel valid
ipix_data  in  8  upstream pixel
opix_ready  out  1  pixel accepted when ipix_valid & opix_ready
icfg_we  in  1  coefficient write strobe
icfg_scale  in  2  bank address
icfg_tap  in  3  tap 0..6 (7 ignored, flags error)
icfg_coef  in  8  coefficient value
oMac_dval  out  1  MAC iDval
oMac_data_s  out  9  MAC idata_s = {1'b0, pixel}
oMac_coef_0..oMac_coef_6  out  8 each  MAC idata_0..idata_6 from selected bank
iMac_odata  in  20  MAC odata
oDval  out  1  result valid (1 cycle)
oData  out  20  result = iMac_odata
oX  out  10  result column 0..IMG_W-1
oY  out  9  result row 0..IMG_H-1
oFrame_done  out  1  1-cycle pulse after last result of frame
oBusy  out  1  high in any state but IDLE
oCfg_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset (async, irst_n low): state IDLE. All outputs 0. Counters, delay lines and the bank select are cleared; coefficient banks reset to 0.
- Config writes:
  - Honoured only in IDLE and when icfg_tap <= 6; written at the clock edge.
  - A write while oBusy=1 or with tap=7 is dropped and sets oCfg_err.
- Bank select: oMac_coef_k = bank[sel][k], where sel is latched at frame start and held constant for the whole frame.
- FSM:
  - IDLE: oBusy=0; an accepted iframe_start -> LPAD with y=0.
  - LPAD: opix_ready=0. Wait for ipix_valid, then strobe oMac_dval with ipix_data (not consumed) on 3 cycles -> ROW.
  - ROW: opix_ready=1. Each accepted pixel strobes oMac_dval with that pixel and is stored as last pixel. After IMG_W accepted pixels -> RPAD.
  - RPAD: opix_ready=0. 3 strobes carrying the stored last pixel -> FLUSH.
  - FLUSH: opix_ready=0. MAC_LAT strobes with pixel 0. Then, if y==IMG_H-1 -> DONE; else y+1 -> LPAD.
  - DONE: wait 1 cycle for the final result, pulse oFrame_done -> IDLE.
- oMac_dval is low on all non-strobe cycles; oMac_data_s[8]=0 always.
- Sample count n: increments on every oMac_dval strobe and clears at LPAD entry.
- Result recovery:
  - n is pipelined through MAC_LAT stages (nd).
  - A MAC capture at strobe cycle t holds the window ending at count nd(t).
  - On cycle t+1: oDval=1 iff nd(t) is in 7..IMG_W+6 and nd(t) != the last emitted nd.
  - Then oX = nd-7, oY = row of that window, oData = iMac_odata.
  - Duplicate captures caused by upstream gaps are dropped. Results with nd outside the range (flush windows) are dropped.
- Exactly IMG_W results per row, oX ascending, no gaps or repeats, independent of ipix_valid gap pattern.
- Arithmetic: no rounding or scaling; oData is passed through at full 20 bits.
- iframe_start while busy is ignored and does not set an error.
- Reset mid-frame aborts immediately. No oFrame_done is issued. The next frame restarts at y=0.

Test Plan:
- IMG_W=8, IMG_H=2, bank0 tap3=1 (others 0), pixels 1..8 contiguous -> row 0 results oData 1..8 at oX 0..7; second row identical at oY=1; exactly one oFrame_done.
- Bank1 all taps=1, constant pixel 10, scale_sel=1 -> every result 70. Row of 1..8 -> oX0 = 1+1+1+1+2+3+4 = 13 and oX7 = 5+6+7+8+8+8+8 = 50 (edge replicate).
- Same stimulus with random ipix_valid gaps of 0-5 cycles -> result sequence bit-identical to the contiguous run, no duplicates.
- Config write during busy and a write with tap=7 -> oCfg_err=1; banks unchanged (rerun of test 1 gives identical output).
- Assert irst_n mid-row 1 -> outputs 0 immediately, no oFrame_done. A new frame produces a complete, correct 2x8 result set.
- Max coefficients 255, pixel 255 -> oData = 7*65025 = 455175 with no overflow; oData[19]=0.
